// File: rtl/pipelined_datapath_if.sv
// rtl/pipelined_datapath_if.sv - issue/result bus of the three-stage pipelined datapath
//
// Purpose: groups the operation handshake, operand/control fields and the
// result/status outputs. The master issues operations, the slave executes them.
// Ports (signals):
//   in_valid/in_ready      issue handshake
//   readnum1/2, writenum   register numbers (ADDR_WIDTH)
//   write, asel, bsel, shift, aluop, vsel, loads   operation control
//   sximm5, sximm8, mdata  immediates / memory data (WIDTH)
//   PC                     program counter (PC_WIDTH)
//   out/out_valid          EX-stage result register and its one-cycle valid
//   Z, N, V                status flags
interface pipelined_datapath_if #(
    parameter int WIDTH    = 16,
    parameter int SIZE     = 8,
    parameter int PC_WIDTH = 8
);
    localparam int ADDR_WIDTH = $clog2(SIZE);

    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] readnum1;
    logic [ADDR_WIDTH-1:0] readnum2;
    logic [ADDR_WIDTH-1:0] writenum;
    logic                  write;
    logic                  asel;
    logic                  bsel;
    logic [1:0]            shift;
    logic [1:0]            aluop;
    logic [1:0]            vsel;
    logic                  loads;
    logic [WIDTH-1:0]      sximm5;
    logic [WIDTH-1:0]      sximm8;
    logic [WIDTH-1:0]      mdata;
    logic [PC_WIDTH-1:0]   PC;
    logic [WIDTH-1:0]      out;
    logic                  out_valid;
    logic                  Z;
    logic                  N;
    logic                  V;

    modport master (
        output in_valid, readnum1, readnum2, writenum, write, asel, bsel,
               shift, aluop, vsel, loads, sximm5, sximm8, mdata, PC,
        input  in_ready, out, out_valid, Z, N, V
    );

    modport slave (
        input  in_valid, readnum1, readnum2, writenum, write, asel, bsel,
               shift, aluop, vsel, loads, sximm5, sximm8, mdata, PC,
        output in_ready, out, out_valid, Z, N, V
    );
endinterface

// File: rtl/pipelined_datapath.sv
// rtl/pipelined_datapath.sv - three-stage (RD/EX/WB) datapath with register file and RAW stall
//
// Purpose: register read at accept, shifter + ALU + status in EX, register
// write-back in WB. Issue stalls while a used source register is the
// destination of a write-enabled op still in EX or WB; there is no forwarding.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    pipelined_datapath_if.slave (issue handshake, operands, result, flags)
module pipelined_datapath #(
    parameter int WIDTH    = 16,
    parameter int SIZE     = 8,
    parameter int PC_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    pipelined_datapath_if.slave  bus
);
    localparam int ADDR_WIDTH = $clog2(SIZE);

    logic [WIDTH-1:0] regfile [SIZE];

    // EX-stage registers (captured at accept)
    logic                  ex_valid;
    logic                  ex_write;
    logic                  ex_asel;
    logic                  ex_bsel;
    logic                  ex_loads;
    logic [ADDR_WIDTH-1:0] ex_writenum;
    logic [1:0]            ex_shift;
    logic [1:0]            ex_aluop;
    logic [1:0]            ex_vsel;
    logic [WIDTH-1:0]      a_reg;
    logic [WIDTH-1:0]      b_reg;
    logic [WIDTH-1:0]      ex_sximm5;
    logic [WIDTH-1:0]      ex_sximm8;
    logic [WIDTH-1:0]      ex_mdata;
    logic [PC_WIDTH-1:0]   ex_pc;

    // WB-stage registers
    logic                  wb_valid;
    logic                  wb_write;
    logic [ADDR_WIDTH-1:0] wb_writenum;
    logic [1:0]            wb_vsel;
    logic [WIDTH-1:0]      c_reg;
    logic [WIDTH-1:0]      wb_sximm8;
    logic [WIDTH-1:0]      wb_mdata;
    logic [PC_WIDTH-1:0]   wb_pc;

    logic z_reg;
    logic n_reg;
    logic v_reg;

    // Hazard detection: only operands that are actually used can stall.
    logic hit1;
    logic hit2;
    logic hazard;
    logic accept;

    always_comb begin
        hit1 = (ex_valid && ex_write && (ex_writenum == bus.readnum1)) ||
               (wb_valid && wb_write && (wb_writenum == bus.readnum1));
        hit2 = (ex_valid && ex_write && (ex_writenum == bus.readnum2)) ||
               (wb_valid && wb_write && (wb_writenum == bus.readnum2));
        hazard = (bus.asel && hit1) || (bus.bsel && hit2);
    end

    assign bus.in_ready = !reset && !hazard;
    assign accept       = bus.in_valid && bus.in_ready;

    // EX datapath
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] shifted_b;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    always_comb begin
        in_a = ex_asel ? a_reg : '0;

        shifted_b = b_reg;
        case (ex_shift)
            2'b01:   shifted_b = {b_reg[WIDTH-2:0], 1'b0};
            2'b10:   shifted_b = {1'b0, b_reg[WIDTH-1:1]};
            2'b11:   shifted_b = {b_reg[WIDTH-1], b_reg[WIDTH-1:1]};
            default: shifted_b = b_reg;
        endcase

        in_b = ex_bsel ? shifted_b : ex_sximm5;

        alu_res = '0;
        alu_ovf = 1'b0;
        case (ex_aluop)
            2'b00: begin
                alu_res = in_a + in_b;
                // Same-sign operands producing a different-sign sum
                alu_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != in_a[WIDTH-1]);
            end
            2'b01: begin
                alu_res = in_a - in_b;
                // Opposite-sign operands where the sign of A is not preserved
                alu_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != in_a[WIDTH-1]);
            end
            2'b10:   alu_res = in_a & in_b;
            default: alu_res = ~in_b;
        endcase
    end

    // WB source selection
    logic [WIDTH-1:0] wb_data;

    always_comb begin
        wb_data = c_reg;
        case (wb_vsel)
            2'b01:   wb_data = wb_sximm8;
            2'b10:   wb_data = WIDTH'(wb_pc);
            2'b11:   wb_data = wb_mdata;
            default: wb_data = c_reg;
        endcase
    end

    // RD stage: operand read and control capture at accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_write    <= 1'b0;
            ex_asel     <= 1'b0;
            ex_bsel     <= 1'b0;
            ex_loads    <= 1'b0;
            ex_writenum <= '0;
            ex_shift    <= '0;
            ex_aluop    <= '0;
            ex_vsel     <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            ex_sximm5   <= '0;
            ex_sximm8   <= '0;
            ex_mdata    <= '0;
            ex_pc       <= '0;
        end else begin
            ex_valid <= accept;
            if (accept) begin
                a_reg       <= regfile[bus.readnum1];
                b_reg       <= regfile[bus.readnum2];
                ex_write    <= bus.write;
                ex_asel     <= bus.asel;
                ex_bsel     <= bus.bsel;
                ex_loads    <= bus.loads;
                ex_writenum <= bus.writenum;
                ex_shift    <= bus.shift;
                ex_aluop    <= bus.aluop;
                ex_vsel     <= bus.vsel;
                ex_sximm5   <= bus.sximm5;
                ex_sximm8   <= bus.sximm8;
                ex_mdata    <= bus.mdata;
                ex_pc       <= bus.PC;
            end
        end
    end

    // EX stage: result register, status flags, WB control
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid    <= 1'b0;
            wb_write    <= 1'b0;
            wb_writenum <= '0;
            wb_vsel     <= '0;
            wb_sximm8   <= '0;
            wb_mdata    <= '0;
            wb_pc       <= '0;
            c_reg       <= '0;
            z_reg       <= 1'b0;
            n_reg       <= 1'b0;
            v_reg       <= 1'b0;
        end else begin
            wb_valid <= ex_valid;
            if (ex_valid) begin
                c_reg       <= alu_res;
                wb_write    <= ex_write;
                wb_writenum <= ex_writenum;
                wb_vsel     <= ex_vsel;
                wb_sximm8   <= ex_sximm8;
                wb_mdata    <= ex_mdata;
                wb_pc       <= ex_pc;
                if (ex_loads) begin
                    z_reg <= (alu_res == '0);
                    n_reg <= alu_res[WIDTH-1];
                    v_reg <= alu_ovf;
                end
            end
        end
    end

    // WB stage: register file write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SIZE; i++) begin
                regfile[i] <= '0;
            end
        end else if (wb_valid && wb_write) begin
            regfile[wb_writenum] <= wb_data;
        end
    end

    assign bus.out       = c_reg;
    assign bus.out_valid = wb_valid;
    assign bus.Z         = z_reg;
    assign bus.N         = n_reg;
    assign bus.V         = v_reg;
endmodule

// File: tb/tb_pipelined_datapath.sv
// tb/tb_pipelined_datapath.sv - self-checking bench for pipelined_datapath
module tb_pipelined_datapath;
    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    pipelined_datapath_if #(.WIDTH(16), .SIZE(8), .PC_WIDTH(8)) dif ();

    pipelined_datapath #(.WIDTH(16), .SIZE(8), .PC_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    typedef struct {
        logic [2:0]  rn, rm, rd;
        logic        wr, asel, bsel;
        logic [1:0]  shift, aluop, vsel;
        logic        loads;
        logic [15:0] imm5, imm8, mdata;
        logic [7:0]  pc;
        logic [15:0] eo;
        logic        ez, en, ev;
    } vec_t;

    typedef struct {
        logic [2:0]  rd;
        logic        wr, loads;
        logic [15:0] res, wbval;
        logic        v;
        int          age;
    } fl_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] rn, rm, rd, input logic wr, asel, bsel,
                                input logic [1:0] shift, aluop, vsel, input logic loads,
                                input logic [15:0] imm5, imm8, mdata, input logic [7:0] pc,
                                input logic [15:0] eo, input logic ez, en, ev);
        vec_t t;
        t.rn = rn; t.rm = rm; t.rd = rd; t.wr = wr; t.asel = asel; t.bsel = bsel;
        t.shift = shift; t.aluop = aluop; t.vsel = vsel; t.loads = loads;
        t.imm5 = imm5; t.imm8 = imm8; t.mdata = mdata; t.pc = pc;
        t.eo = eo; t.ez = ez; t.en = en; t.ev = ev;
        return t;
    endfunction

    // Load immediate into rd; ALU computes 0+0 so out is 0.
    function automatic vec_t mov(input logic [2:0] rd, input logic [15:0] val,
                                 input logic z, n, v);
        return mk(3'd0, 3'd0, rd, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0,
                  16'd0, val, 16'd0, 8'd0, 16'd0, z, n, v);
    endfunction

    // Read register r back on out as r + 0, no write, flags untouched.
    function automatic vec_t rbk(input logic [2:0] r, input logic [15:0] val,
                                 input logic z, n, v);
        return mk(r, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0,
                  16'd0, 16'd0, 16'd0, 8'd0, val, z, n, v);
    endfunction

    task automatic drive(input vec_t v, input logic iv);
        dif.readnum1 = v.rn;  dif.readnum2 = v.rm;  dif.writenum = v.rd;
        dif.write = v.wr;     dif.asel = v.asel;    dif.bsel = v.bsel;
        dif.shift = v.shift;  dif.aluop = v.aluop;  dif.vsel = v.vsel;
        dif.loads = v.loads;  dif.sximm5 = v.imm5;  dif.sximm8 = v.imm8;
        dif.mdata = v.mdata;  dif.PC = v.pc;
        dif.in_valid = iv;
    endtask

    // Issue one op into a drained pipeline and check its result and flags.
    task automatic run_vec(input vec_t v, input string name);
        drive(v, 1'b1);
        #1;
        chk({name, "_ready"}, dif.in_ready, 1);
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        @(posedge clk); #1;
        chk({name, "_valid"}, dif.out_valid, 1);
        chk({name, "_out"}, dif.out, v.eo);
        chk({name, "_flags"}, {dif.Z, dif.N, dif.V}, {v.ez, v.en, v.ev});
        @(posedge clk); #1;
        chk({name, "_valid_drop"}, dif.out_valid, 0);
    endtask

    // Reference model: plain signed-integer arithmetic.
    function automatic int sval(input logic [15:0] x);
        return x[15] ? int'(x) - 65536 : int'(x);
    endfunction

    function automatic logic [15:0] ref_shift(input logic [1:0] sh, input logic [15:0] b);
        int sb;
        sb = sval(b);
        case (sh)
            2'd1:    return 16'(int'(b) * 2);
            2'd2:    return 16'(int'(b) / 2);
            2'd3:    return 16'(sb >>> 1);
            default: return b;
        endcase
    endfunction

    task automatic ref_alu(input logic [1:0] op, input logic [15:0] a, b,
                           output logic [15:0] r, output logic v);
        int s;
        v = 1'b0;
        case (op)
            2'd0: begin s = sval(a) + sval(b); r = 16'(s); v = (s > 32767) || (s < -32768); end
            2'd1: begin s = sval(a) - sval(b); r = 16'(s); v = (s > 32767) || (s < -32768); end
            2'd2: r = a & b;
            default: r = ~b;
        endcase
    endtask

    vec_t        tbl[$];
    vec_t        cur;
    fl_t         q[$];
    fl_t         nf;
    logic [15:0] mreg [8];
    logic [15:0] m_out;
    logic        mz, mn, mv;
    logic        iv, exp_rdy, exp_ov, acc;
    logic [15:0] opa, opb;

    initial begin
        drive(mov(3'd0, 16'd0, 1'b0, 1'b0, 1'b0), 1'b0);

        // Reset state and reset mid-operation
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready_low", dif.in_ready, 0);
        reset = 1'b0;
        #1;
        chk("rst_ready_high", dif.in_ready, 1);
        chk("rst_out", dif.out, 0);
        chk("rst_out_valid", dif.out_valid, 0);
        chk("rst_flags", {dif.Z, dif.N, dif.V}, 3'b000);
        cur = mk(3'd0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0,
                 16'd3, 16'd5, 16'd0, 8'd0, 16'd3, 1'b0, 1'b0, 1'b0);
        drive(cur, 1'b1);
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_out_valid", dif.out_valid, 1);
        chk("mid_out", dif.out, 16'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_out", dif.out, 0);
        chk("mid_rst_valid", dif.out_valid, 0);
        chk("mid_rst_ready", dif.in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_vec(rbk(3'd1, 16'd0, 1'b0, 1'b0, 1'b0), "mid_r1_zero");

        // Directed vectors
        tbl.push_back(mov(3'd0, 16'd7, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mov(3'd2, 16'd3, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(3'd0, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 1'b1,
                         16'd0, 16'd0, 16'd0, 8'd0, 16'd10, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(3'd0, 3'd2, 3'd4, 1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 2'd0, 1'b1,
                         16'd0, 16'd0, 16'd0, 8'd0, 16'd4, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mov(3'd5, 16'h8000, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mov(3'd6, 16'h0001, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(3'd5, 3'd6, 3'd7, 1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 2'd0, 1'b1,
                         16'd0, 16'd0, 16'd0, 8'd0, 16'h7FFF, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(3'd0, 3'd2, 3'd0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd2, 2'd0, 1'b0,
                         16'd0, 16'd0, 16'd0, 8'd0, 16'd3, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mov(3'd1, 16'd5, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 2'd0, 1'b1,
                         16'd5, 16'd0, 16'd0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mov(3'd6, 16'h8002, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(3'd0, 3'd6, 3'd0, 1'b0, 1'b0, 1'b1, 2'd3, 2'd0, 2'd0, 1'b1,
                         16'd0, 16'd0, 16'd0, 8'd0, 16'hC001, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(3'd0, 3'd6, 3'd0, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0, 1'b0,
                         16'd0, 16'd0, 16'd0, 8'd0, 16'h4001, 1'b0, 1'b1, 1'b0));
        tbl.push_back(mk(3'd0, 3'd6, 3'd0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 2'd0, 1'b1,
                         16'd0, 16'd0, 16'd0, 8'd0, 16'h0004, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(3'd0, 3'd6, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd3, 2'd0, 1'b1,
                         16'd0, 16'd0, 16'd0, 8'd0, 16'h7FFD, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0,
                         16'd0, 16'd0, 16'd0, 8'hAB, 16'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(rbk(3'd2, 16'h00AB, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd3, 1'b0,
                         16'd0, 16'd0, 16'h1234, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(rbk(3'd3, 16'h1234, 1'b0, 1'b0, 1'b0));
        tbl.push_back(rbk(3'd7, 16'h7FFF, 1'b0, 1'b0, 1'b0));
        tbl.push_back(rbk(3'd4, 16'd4, 1'b0, 1'b0, 1'b0));
        tbl.push_back(rbk(3'd0, 16'd7, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(3'd5, 3'd5, 3'd0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 1'b1,
                         16'd0, 16'd0, 16'd0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(3'd0, 3'd2, 3'd0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd2, 2'd0, 1'b0,
                         16'd0, 16'd0, 16'd0, 8'd0, 16'h0003, 1'b1, 1'b0, 1'b1));
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Back-to-back independent ops
        run_vec(mov(3'd2, 16'd3, 1'b1, 1'b0, 1'b1), "setup_r2");
        drive(mk(3'd0, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0,
                 16'd0, 16'd0, 16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0), 1'b1);
        #1; chk("b2b_ready0", dif.in_ready, 1);
        @(posedge clk); #1;
        drive(mk(3'd0, 3'd2, 3'd4, 1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 2'd0, 1'b0,
                 16'd0, 16'd0, 16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0), 1'b1);
        #1; chk("b2b_ready1", dif.in_ready, 1);
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        chk("b2b_valid0", dif.out_valid, 1);
        chk("b2b_out0", dif.out, 16'd10);
        @(posedge clk); #1;
        chk("b2b_valid1", dif.out_valid, 1);
        chk("b2b_out1", dif.out, 16'd4);
        @(posedge clk); #1;
        chk("b2b_valid_drop", dif.out_valid, 0);

        // RAW stall: AND reads R1 right after ADD writes it
        drive(mk(3'd0, 3'd2, 3'd1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0,
                 16'd0, 16'd0, 16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0), 1'b1);
        #1; chk("raw_ready_prod", dif.in_ready, 1);
        @(posedge clk); #1;
        drive(mk(3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd2, 2'd0, 1'b0,
                 16'd0, 16'd0, 16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0), 1'b1);
        #1; chk("raw_stall_ex", dif.in_ready, 0);
        @(posedge clk); #1;
        chk("raw_prod_out", dif.out, 16'd10);
        chk("raw_stall_wb", dif.in_ready, 0);
        @(posedge clk); #1;
        chk("raw_bubble", dif.out_valid, 0);
        chk("raw_release", dif.in_ready, 1);
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("raw_dep_valid", dif.out_valid, 1);
        chk("raw_dep_out", dif.out, 16'd2);
        @(posedge clk); #1;

        // Same shape with unused operands: no stall
        drive(mk(3'd0, 3'd2, 3'd1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0,
                 16'd0, 16'd0, 16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0), 1'b1);
        @(posedge clk); #1;
        drive(mk(3'd1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0,
                 16'd9, 16'd0, 16'd0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0), 1'b1);
        #1; chk("unused_no_stall", dif.in_ready, 1);
        @(posedge clk); #1;
        dif.in_valid = 1'b0;
        chk("unused_out0", dif.out, 16'd10);
        @(posedge clk); #1;
        chk("unused_valid1", dif.out_valid, 1);
        chk("unused_out1", dif.out, 16'd9);

        // Idle handshake
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("idle_valid", dif.out_valid, 0);
            chk("idle_ready", dif.in_ready, 1);
            chk("idle_out_hold", dif.out, 16'd9);
        end
        run_vec(rbk(3'd1, 16'd10, 1'b1, 1'b0, 1'b1), "idle_r1");

        // Randomized run against the reference model
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) mreg[i] = 16'd0;
        m_out = 16'd0; mz = 1'b0; mn = 1'b0; mv = 1'b0;
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            exp_ov = 1'b0;
            foreach (q[k]) if (q[k].age == 2) exp_ov = 1'b1;
            chk("rnd_out_valid", dif.out_valid, exp_ov);
            chk("rnd_out", dif.out, m_out);
            chk("rnd_flags", {dif.Z, dif.N, dif.V}, {mz, mn, mv});

            cur.rn = 3'($urandom_range(0, 7));  cur.rm = 3'($urandom_range(0, 7));
            cur.rd = 3'($urandom_range(0, 7));  cur.wr = ($urandom_range(0, 9) < 6);
            cur.asel = 1'($urandom);  cur.bsel = 1'($urandom);
            cur.shift = 2'($urandom); cur.aluop = 2'($urandom); cur.vsel = 2'($urandom);
            cur.loads = 1'($urandom);
            cur.imm5 = 16'($urandom); cur.imm8 = 16'($urandom);
            cur.mdata = 16'($urandom); cur.pc = 8'($urandom);
            iv = ($urandom_range(0, 3) != 0);
            drive(cur, iv);
            #1;
            exp_rdy = 1'b1;
            foreach (q[k]) begin
                if ((q[k].age == 1 || q[k].age == 2) && q[k].wr &&
                    ((cur.asel && cur.rn == q[k].rd) || (cur.bsel && cur.rm == q[k].rd)))
                    exp_rdy = 1'b0;
            end
            chk("rnd_in_ready", dif.in_ready, exp_rdy);
            acc = iv && exp_rdy;
            if (acc) begin
                opa = cur.asel ? mreg[cur.rn] : 16'd0;
                opb = cur.bsel ? ref_shift(cur.shift, mreg[cur.rm]) : cur.imm5;
                ref_alu(cur.aluop, opa, opb, nf.res, nf.v);
                nf.rd = cur.rd; nf.wr = cur.wr; nf.loads = cur.loads; nf.age = 1;
                case (cur.vsel)
                    2'd0: nf.wbval = nf.res;
                    2'd1: nf.wbval = cur.imm8;
                    2'd2: nf.wbval = {8'd0, cur.pc};
                    default: nf.wbval = cur.mdata;
                endcase
            end
            @(posedge clk);
            foreach (q[k]) begin
                q[k].age++;
                if (q[k].age == 2) begin
                    m_out = q[k].res;
                    if (q[k].loads) begin
                        mz = (q[k].res == 16'd0); mn = q[k].res[15]; mv = q[k].v;
                    end
                end
            end
            while (q.size() > 0 && q[0].age >= 3) begin
                if (q[0].wr) mreg[q[0].rd] = q[0].wbval;
                void'(q.pop_front());
            end
            if (acc) q.push_back(nf);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
